// File: rtl/calc_pkg.sv
// Shared calculator definitions: decoder FSM states and active-low
// seven-segment encodings (index 0 = segment a, index 6 = segment g).
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;

  // Digits 10..15 never come out of the converter; they map to blank.
  function automatic seg_t digit_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/result_bcd_decoder_if.sv
// Result-to-display interface: the master issues conversion requests,
// the slave (decoder) returns digits, sign and segment drives.
interface result_bcd_decoder_if;
  import calc_pkg::*;

  logic       start;
  logic [7:0] value;
  logic       signed_mode;
  logic       busy;
  logic       done;
  logic       neg;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       HEX3;
  seg_t       HEX2;
  seg_t       HEX1;
  seg_t       HEX0;

  modport master (
    output start, value, signed_mode,
    input  busy, done, neg, bcd2, bcd1, bcd0, HEX3, HEX2, HEX1, HEX0
  );

  modport slave (
    input  start, value, signed_mode,
    output busy, done, neg, bcd2, bcd1, bcd0, HEX3, HEX2, HEX1, HEX0
  );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output seg_t       seg
);

  // Select blank or the digit's segment pattern.
  always_comb begin
    seg = blank ? SEG_BLANK : digit_to_seg(digit);
  end

endmodule

// File: rtl/result_bcd_decoder.sv
// Sequential binary-to-BCD display decoder: sign/magnitude split on accept,
// eight double-dabble iterations, then registered digits and segment drives.
module result_bcd_decoder
  import calc_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  result_bcd_decoder_if.slave  bus
);

  state_t      state;
  logic [7:0]  mag;
  logic [11:0] scratch;
  logic [2:0]  cnt;
  logic        neg_pending;

  logic [11:0] adj;
  logic [11:0] next_scratch;
  logic        blank2;
  logic        blank1;
  seg_t        seg2;
  seg_t        seg1;
  seg_t        seg0;

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next magnitude bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    adj = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
    next_scratch = {adj[10:0], mag[7]};
    blank2 = (next_scratch[11:8] == 4'd0);
    blank1 = blank2 && (next_scratch[7:4] == 4'd0);
  end

  // Segment patterns for the digits that will be registered on the final step.
  seg7_decoder u_seg2 (.digit(next_scratch[11:8]), .blank(blank2), .seg(seg2));
  seg7_decoder u_seg1 (.digit(next_scratch[7:4]),  .blank(blank1), .seg(seg1));
  seg7_decoder u_seg0 (.digit(next_scratch[3:0]),  .blank(1'b0),   .seg(seg0));

  // Control FSM, conversion datapath and registered display outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mag         <= '0;
      scratch     <= '0;
      cnt         <= '0;
      neg_pending <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.neg     <= 1'b0;
      bus.bcd2    <= '0;
      bus.bcd1    <= '0;
      bus.bcd0    <= '0;
      bus.HEX3    <= 1'b1;
      bus.HEX2    <= SEG_BLANK;
      bus.HEX1    <= SEG_BLANK;
      bus.HEX0    <= SEG_0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (bus.start) begin
            if (bus.signed_mode && bus.value[7]) begin
              mag         <= ~bus.value + 8'd1;
              neg_pending <= 1'b1;
            end else begin
              mag         <= bus.value;
              neg_pending <= 1'b0;
            end
            scratch  <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          scratch <= next_scratch;
          mag     <= {mag[6:0], 1'b0};
          cnt     <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            bus.bcd2 <= next_scratch[11:8];
            bus.bcd1 <= next_scratch[7:4];
            bus.bcd0 <= next_scratch[3:0];
            bus.neg  <= neg_pending;
            bus.HEX3 <= ~neg_pending;
            bus.HEX2 <= seg2;
            bus.HEX1 <= seg1;
            bus.HEX0 <= seg0;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
